// File: rtl/counter_pkg.sv
// Shared encodings for the bounded up/down counter.
// BMODE selects what happens when a step would cross MIN or MAX.
package counter_pkg;

    localparam logic [1:0] BM_WRAP = 2'b00;  // jump to the opposite bound
    localparam logic [1:0] BM_SAT  = 2'b01;  // stick at the bound being crossed
    localparam logic [1:0] BM_PING = 2'b10;  // bounce and reverse direction
    // 2'b11 is not named; the core handles it the same way as BM_WRAP.

endpackage : counter_pkg

// File: rtl/tick_prescaler.sv
// Tick prescaler: fires one tick every DIV+1 enabled cycles.
// SS=0 freezes the phase so a paused count resumes where it left off.
// clear restarts the phase and blocks the tick in that cycle.
module tick_prescaler #(
    parameter int PRESCALE_W = 8
) (
    input  logic                  Clk,
    input  logic                  RST,
    input  logic                  SS,
    input  logic                  clear,
    input  logic [PRESCALE_W-1:0] DIV,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] pre_q;
    logic [PRESCALE_W-1:0] pre_d;

    // The tick fires in the enabled cycle where the phase reaches DIV.
    assign tick = SS && !clear && (pre_q == DIV);

    // Next phase: clear wins, then advance or restart while enabled.
    always_comb begin
        pre_d = pre_q;
        if (clear) begin
            pre_d = '0;
        end else if (SS) begin
            if (tick) begin
                pre_d = '0;
            end else begin
                pre_d = pre_q + 1'b1;
            end
        end
    end

    // Phase register with asynchronous reset.
    always_ff @(posedge Clk or posedge RST) begin
        if (RST) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

endmodule : tick_prescaler

// File: rtl/bounded_updown_counter.sv
// Bounded up/down counter with run-time MIN/MAX bounds, programmable step,
// a tick prescaler and selectable boundary behaviour (wrap, saturate,
// ping-pong). Also provides a synchronous load, a one-cycle terminal-count
// pulse and a registered bound-error flag.
module bounded_updown_counter
    import counter_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int PRESCALE_W = 8
) (
    input  logic                  Clk,
    input  logic                  RST,
    input  logic [WIDTH-1:0]      MIN,
    input  logic [WIDTH-1:0]      MAX,
    input  logic [WIDTH-1:0]      STEP,
    input  logic [PRESCALE_W-1:0] DIV,
    input  logic                  SS,
    input  logic                  MODE,
    input  logic [1:0]            BMODE,
    input  logic                  LOAD,
    input  logic [WIDTH-1:0]      LOAD_VAL,
    output logic [WIDTH-1:0]      OUT,
    output logic                  TC,
    output logic                  DIR,
    output logic                  ERR
);

    logic [WIDTH-1:0] out_q, out_d;
    logic             tc_q, tc_d;
    logic             dir_q, dir_d;
    logic             err_q, err_d;

    logic             tick;
    logic             is_sat, is_ping;
    logic             dir_eff;
    logic             bound_err;
    logic             tick_ok;
    logic             in_range;

    // Bound arithmetic is done one bit wider so sums never wrap.
    logic [WIDTH:0]   out_x, min_x, max_x, step_x;
    logic [WIDTH:0]   up_sum;      // OUT + STEP
    logic [WIDTH:0]   dn_lim;      // MIN + STEP
    logic             up_ovf, dn_ovf;
    logic [WIDTH-1:0] up_next, dn_next;
    logic [WIDTH-1:0] ping_up_turn, ping_dn_turn;

    tick_prescaler #(
        .PRESCALE_W(PRESCALE_W)
    ) u_prescaler (
        .Clk  (Clk),
        .RST  (RST),
        .SS   (SS),
        .clear(LOAD),
        .DIV  (DIV),
        .tick (tick)
    );

    assign is_sat  = (BMODE == BM_SAT);
    assign is_ping = (BMODE == BM_PING);

    // Ping-pong owns its direction register; the other modes follow MODE.
    assign dir_eff = is_ping ? dir_q : MODE;

    // Ticks are ignored while the bounds are inverted, both in the cycle the
    // inversion appears and while the registered flag is still set.
    assign bound_err = (MIN > MAX);
    assign tick_ok   = tick && !err_q && !bound_err;
    assign in_range  = (out_q >= MIN) && (out_q <= MAX);

    assign out_x  = {1'b0, out_q};
    assign min_x  = {1'b0, MIN};
    assign max_x  = {1'b0, MAX};
    assign step_x = {1'b0, STEP};

    assign up_sum  = out_x + step_x;
    assign dn_lim  = min_x + step_x;
    assign up_ovf  = (up_sum > max_x);
    assign dn_ovf  = (out_x < dn_lim);
    assign up_next = up_sum[WIDTH-1:0];
    assign dn_next = out_q - STEP;

    // Bounce targets: one step back from the bound, clamped to the other one.
    // MAX-STEP < MIN is the same test as MAX < MIN+STEP.
    assign ping_up_turn = (max_x < dn_lim) ? MIN : (MAX - STEP);
    assign ping_dn_turn = (dn_lim > max_x) ? MAX : dn_lim[WIDTH-1:0];

    // Next-state logic: LOAD beats a tick, a tick beats hold.
    always_comb begin
        out_d = out_q;
        tc_d  = 1'b0;
        dir_d = dir_q;
        err_d = bound_err;
        if (LOAD) begin
            out_d = LOAD_VAL;
            dir_d = MODE;
        end else if (tick_ok) begin
            if (!in_range) begin
                out_d = dir_eff ? MIN : MAX;
            end else if (STEP != '0) begin
                if (dir_eff) begin
                    if (is_ping) begin
                        if (out_q == MAX) begin
                            out_d = ping_up_turn;
                            dir_d = 1'b0;
                            tc_d  = 1'b1;
                        end else if (up_ovf) begin
                            out_d = MAX;
                        end else begin
                            out_d = up_next;
                        end
                    end else if (up_ovf) begin
                        if (is_sat) begin
                            out_d = MAX;
                            tc_d  = (out_q != MAX);
                        end else begin
                            out_d = MIN;
                            tc_d  = 1'b1;
                        end
                    end else begin
                        out_d = up_next;
                    end
                end else begin
                    if (is_ping) begin
                        if (out_q == MIN) begin
                            out_d = ping_dn_turn;
                            dir_d = 1'b1;
                            tc_d  = 1'b1;
                        end else if (dn_ovf) begin
                            out_d = MIN;
                        end else begin
                            out_d = dn_next;
                        end
                    end else if (dn_ovf) begin
                        if (is_sat) begin
                            out_d = MIN;
                            tc_d  = (out_q != MIN);
                        end else begin
                            out_d = MAX;
                            tc_d  = 1'b1;
                        end
                    end else begin
                        out_d = dn_next;
                    end
                end
            end
        end
    end

    // Counter state registers with asynchronous reset.
    always_ff @(posedge Clk or posedge RST) begin
        if (RST) begin
            out_q <= '0;
            tc_q  <= 1'b0;
            dir_q <= 1'b1;
            err_q <= 1'b0;
        end else begin
            out_q <= out_d;
            tc_q  <= tc_d;
            dir_q <= dir_d;
            err_q <= err_d;
        end
    end

    assign OUT = out_q;
    assign TC  = tc_q;
    assign DIR = dir_eff;
    assign ERR = err_q;

endmodule : bounded_updown_counter
